// File: rtl/lockbox_bank_pkg.sv
// Shared encodings for the multi-slot lockbox: opcodes, response status and slot state.
package lockbox_bank_pkg;

    typedef enum logic [1:0] {
        OP_STORE = 2'd0,
        OP_GET   = 2'd1,
        OP_WIPE  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_NONE     = 3'd0,
        ST_OK       = 3'd1,
        ST_MISMATCH = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_REJECT   = 3'd4,
        ST_BUSY     = 3'd5
    } status_e;

    typedef enum logic [1:0] {
        SL_EMPTY  = 2'd0,
        SL_FULL   = 2'd1,
        SL_LOCKED = 2'd2
    } slot_state_e;

endpackage

// File: rtl/lockbox_bank_slot.sv
// One secret/password slot with failed-attempt counter and permanent lockout.
// Outputs are zero unless req is high, so the top can OR all slots together.
module lockbox_bank_slot
    import lockbox_bank_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] secret,
    input  logic [WIDTH-1:0] password,
    output logic [2:0]       status,
    output logic [WIDTH-1:0] data,
    output logic             fail
);
    localparam int CW = $clog2(MAX_TRIES + 1);

    slot_state_e      state;
    logic [WIDTH-1:0] sec_q;
    logic [WIDTH-1:0] pw_q;
    logic [CW-1:0]    cnt_q;
    logic             match;
    logic [CW-1:0]    cnt_inc;
    logic             lock_now;

    assign match    = (password == pw_q);
    assign cnt_inc  = cnt_q + CW'(1);
    assign lock_now = (cnt_inc == CW'(MAX_TRIES));

    always_comb begin
        status = ST_NONE;
        data   = '0;
        fail   = 1'b0;
        if (req) begin
            unique case (state)
                SL_EMPTY:  status = (op == OP_GET) ? ST_REJECT : ST_OK;
                SL_FULL: begin
                    if (op == OP_STORE) status = ST_REJECT;
                    else if (op == OP_GET) begin
                        if (match) begin
                            status = ST_OK;
                            data   = sec_q;
                        end else begin
                            fail   = 1'b1;
                            status = lock_now ? ST_LOCKED : ST_MISMATCH;
                        end
                    end else status = ST_OK;
                end
                SL_LOCKED: begin
                    if (op == OP_STORE)    status = ST_REJECT;
                    else if (op == OP_GET) status = ST_LOCKED;
                    else                   status = ST_OK;
                end
                default:   status = ST_REJECT;
            endcase
        end
    end

    // Counter stops at MAX_TRIES because the slot leaves FULL on that failure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SL_EMPTY;
            sec_q <= '0;
            pw_q  <= '0;
            cnt_q <= '0;
        end else if (req) begin
            if (op == OP_WIPE || (state == SL_FULL && op == OP_GET && match)) begin
                state <= SL_EMPTY;
                sec_q <= '0;
                pw_q  <= '0;
                cnt_q <= '0;
            end else if (state == SL_EMPTY && op == OP_STORE) begin
                state <= SL_FULL;
                sec_q <= secret;
                pw_q  <= password;
                cnt_q <= '0;
            end else if (state == SL_FULL && op == OP_GET) begin
                cnt_q <= cnt_inc;
                if (lock_now) begin
                    sec_q <= '0;
                    state <= SL_LOCKED;
                end
            end
        end
    end

endmodule

// File: rtl/lockbox_bank.sv
// Multi-slot lockbox: slot decode, response mux and registered response.
// Define LOCKBOX_BANK_PENALTY_EN to stall all requests for PENALTY_CYCLES after a failed GET.
module lockbox_bank
    import lockbox_bank_pkg::*;
#(
    parameter int WIDTH          = 128,
    parameter int SLOTS          = 4,
    parameter int MAX_TRIES      = 3,
    parameter int PENALTY_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic [1:0]               op,
    input  logic [$clog2(SLOTS)-1:0] slot,
    input  logic [WIDTH-1:0]         secret,
    input  logic [WIDTH-1:0]         password,
    output logic [WIDTH-1:0]         out,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_status,
    output logic                     busy
);
    localparam int SW = $clog2(SLOTS);

    logic [SLOTS-1:0]            slot_req;
    logic [SLOTS-1:0][2:0]       slot_st;
    logic [SLOTS-1:0][WIDTH-1:0] slot_data;
    logic [SLOTS-1:0]            slot_fail;
    logic                        addr_ok;
    logic                        op_ok;
    logic                        accept;
    logic [2:0]                  st_or;
    logic [WIDTH-1:0]            data_or;
    logic [2:0]                  st_nxt;

    assign addr_ok = (int'(slot) < SLOTS);
    assign op_ok   = (op != OP_RSVD);
    assign accept  = en && addr_ok && op_ok && !busy;

    genvar g;
    generate
        for (g = 0; g < SLOTS; g++) begin : g_slot
            assign slot_req[g] = accept && (slot == SW'(g));
            lockbox_bank_slot #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) u_slot (
                .clk     (clk),
                .resetn  (resetn),
                .req     (slot_req[g]),
                .op      (op),
                .secret  (secret),
                .password(password),
                .status  (slot_st[g]),
                .data    (slot_data[g]),
                .fail    (slot_fail[g])
            );
        end
    endgenerate

    always_comb begin
        st_or   = '0;
        data_or = '0;
        for (int i = 0; i < SLOTS; i++) begin
            st_or   = st_or | slot_st[i];
            data_or = data_or | slot_data[i];
        end
        if (!en)                  st_nxt = ST_NONE;
        else if (busy)            st_nxt = ST_BUSY;
        else if (!addr_ok || !op_ok) st_nxt = ST_REJECT;
        else                      st_nxt = st_or;
    end

`ifdef LOCKBOX_BANK_PENALTY_EN
    localparam int PW = $clog2(PENALTY_CYCLES + 1);
    logic [PW-1:0] pen_cnt;

    // Failures cannot happen while busy, so a load never extends a running stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)           pen_cnt <= '0;
        else if (|slot_fail)   pen_cnt <= PW'(PENALTY_CYCLES);
        else if (pen_cnt != 0) pen_cnt <= pen_cnt - PW'(1);
    end
    assign busy = (pen_cnt != '0);
`else
    logic unused_fail;
    localparam int unused_pen = PENALTY_CYCLES;
    assign unused_fail = |slot_fail;
    assign busy        = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid  <= 1'b0;
            rsp_status <= ST_NONE;
            out        <= '0;
        end else begin
            rsp_valid  <= en;
            rsp_status <= st_nxt;
            out        <= data_or;
        end
    end

endmodule

// File: tb/tb_lockbox_bank.sv
// Bench for lockbox_bank: directed plan plus random traffic against a slot-array reference model.
module tb_lockbox_bank;
    import lockbox_bank_pkg::*;

    localparam int W         = 128;
    localparam int SLOTS     = 4;
    localparam int SW        = $clog2(SLOTS);
    localparam int MAX_TRIES = 3;
    localparam int PENALTY   = 8;
`ifdef LOCKBOX_BANK_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int M_EMPTY = 0, M_FULL = 1, M_LOCKED = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    op = '0;
    logic [SW-1:0] slot = '0;
    logic [W-1:0]  secret = '0;
    logic [W-1:0]  password = '0;
    logic [W-1:0]  out;
    logic          rsp_valid;
    logic [2:0]    rsp_status;
    logic          busy;

    lockbox_bank #(.WIDTH(W), .SLOTS(SLOTS), .MAX_TRIES(MAX_TRIES), .PENALTY_CYCLES(PENALTY)) dut (
        .clk(clk), .resetn(resetn), .en(en), .op(op), .slot(slot), .secret(secret),
        .password(password), .out(out), .rsp_valid(rsp_valid), .rsp_status(rsp_status), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: each slot is a state code, secret, password and try count.
    int           m_state[SLOTS];
    logic [W-1:0] m_sec[SLOTS];
    logic [W-1:0] m_pw[SLOTS];
    int           m_cnt[SLOTS];
    int           m_pen;

    logic [W-1:0] obs_out;
    logic [2:0]   obs_st;
    logic         obs_busy;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_state[i] = M_EMPTY;
            m_sec[i] = '0;
            m_pw[i] = '0;
            m_cnt[i] = 0;
        end
        m_pen = 0;
    endtask

    task automatic clear_slot(input int s);
        m_state[s] = M_EMPTY;
        m_sec[s] = '0;
        m_pw[s] = '0;
        m_cnt[s] = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input string tag, input bit e, input logic [1:0] o, input logic [SW-1:0] s,
                        input logic [W-1:0] sec, input logic [W-1:0] pw);
        logic [2:0]   e_st;
        logic [W-1:0] e_out;
        bit           fail;
        int           si;
        si = int'(s);
        e_st = ST_NONE;
        e_out = '0;
        fail = 1'b0;
        if (e) begin
            if (m_pen > 0) e_st = ST_BUSY;
            else if (o == 2'd3 || si >= SLOTS) e_st = ST_REJECT;
            else if (o == 2'd2) begin
                e_st = ST_OK;
                clear_slot(si);
            end else if (o == 2'd0) begin
                if (m_state[si] == M_EMPTY) begin
                    m_state[si] = M_FULL;
                    m_sec[si] = sec;
                    m_pw[si] = pw;
                    m_cnt[si] = 0;
                    e_st = ST_OK;
                end else e_st = ST_REJECT;
            end else begin
                if (m_state[si] == M_EMPTY) e_st = ST_REJECT;
                else if (m_state[si] == M_LOCKED) e_st = ST_LOCKED;
                else if (pw == m_pw[si]) begin
                    e_st = ST_OK;
                    e_out = m_sec[si];
                    clear_slot(si);
                end else begin
                    fail = 1'b1;
                    m_cnt[si] = m_cnt[si] + 1;
                    if (m_cnt[si] >= MAX_TRIES) begin
                        m_state[si] = M_LOCKED;
                        m_sec[si] = '0;
                        e_st = ST_LOCKED;
                    end else e_st = ST_MISMATCH;
                end
            end
        end
        if (PEN && fail) m_pen = PENALTY;
        else if (m_pen > 0) m_pen = m_pen - 1;

        en = e; op = o; slot = s; secret = sec; password = pw;
        @(posedge clk);
        #1;
        obs_out = out;
        obs_st = rsp_status;
        obs_busy = busy;
        check({tag, ".valid"}, W'(rsp_valid), W'(e));
        check({tag, ".status"}, W'(rsp_status), W'(e_st));
        check({tag, ".out"}, out, e_out);
        check({tag, ".busy"}, W'(busy), W'(m_pen > 0));
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_free();
        int n;
        n = 0;
        while (m_pen > 0 && n < 50) begin
            step("idle", 1'b0, 2'd0, '0, '0, '0);
            n++;
        end
    endtask

    initial begin
        int busy_len;
        model_reset();
        #12;
        check("rst.valid", W'(rsp_valid), '0);
        check("rst.status", W'(rsp_status), W'(ST_NONE));
        check("rst.out", out, '0);
        check("rst.busy", W'(busy), '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Store/get/repeat-get on slot 1
        step("s1_store", 1'b1, 2'd0, 2'd1, W'(16'hAAAA), W'(16'h1234));
        step("s1_get", 1'b1, 2'd1, 2'd1, '0, W'(16'h1234));
        check("s1_get_secret", obs_out, W'(16'hAAAA));
        check("s1_get_ok", W'(obs_st), W'(ST_OK));
        step("s1_reget", 1'b1, 2'd1, 2'd1, '0, W'(16'h1234));
        check("s1_reget_reject", W'(obs_st), W'(ST_REJECT));

        // Double store on slot 0
        step("s0_store", 1'b1, 2'd0, 2'd0, W'(32'hCAFE_F00D), W'(8'h55));
        step("s0_store2", 1'b1, 2'd0, 2'd0, W'(32'hDEAD_BEEF), W'(8'h66));
        check("s0_store2_reject", W'(obs_st), W'(ST_REJECT));
        step("s0_get", 1'b1, 2'd1, 2'd0, '0, W'(8'h55));
        check("s0_get_orig", obs_out, W'(32'hCAFE_F00D));

        // Lockout on slot 2 with an all-zero stored password
        step("s2_store", 1'b1, 2'd0, 2'd2, W'(16'h7777), '0);
        for (int i = 0; i < MAX_TRIES; i++) begin
            step("s2_bad", 1'b1, 2'd1, 2'd2, '0, W'(8'h01));
            check("s2_bad_status", W'(obs_st), (i == MAX_TRIES - 1) ? W'(ST_LOCKED) : W'(ST_MISMATCH));
            wait_free();
        end
        step("s2_locked_get", 1'b1, 2'd1, 2'd2, '0, '0);
        check("s2_locked", W'(obs_st), W'(ST_LOCKED));
        step("s2_wipe", 1'b1, 2'd2, 2'd2, '0, '0);
        step("s2_restore", 1'b1, 2'd0, 2'd2, W'(16'h1111), W'(8'h02));
        check("s2_restore_ok", W'(obs_st), W'(ST_OK));

        // Isolation between slot 0 and slot 3
        step("iso_s0", 1'b1, 2'd0, 2'd0, W'(16'h0A0A), W'(8'h10));
        step("iso_s3", 1'b1, 2'd0, 2'd3, W'(16'h0B0B), W'(8'h30));
        for (int i = 0; i < 2; i++) begin
            step("iso_bad0", 1'b1, 2'd1, 2'd0, '0, W'(8'h11));
            wait_free();
        end
        step("iso_get3", 1'b1, 2'd1, 2'd3, '0, W'(8'h30));
        check("iso_get3_data", obs_out, W'(16'h0B0B));
        step("iso_bad0_3rd", 1'b1, 2'd1, 2'd0, '0, W'(8'h11));
        check("iso_lock0", W'(obs_st), W'(ST_LOCKED));
        wait_free();
        step("iso_wipe0", 1'b1, 2'd2, 2'd0, '0, '0);
        step("rsvd_op", 1'b1, 2'd3, 2'd1, '0, '0);

`ifdef LOCKBOX_BANK_PENALTY_EN
        step("pen_store", 1'b1, 2'd0, 2'd1, W'(16'h4242), W'(8'h77));
        step("pen_bad", 1'b1, 2'd1, 2'd1, '0, W'(8'h78));
        busy_len = obs_busy ? 1 : 0;
        step("pen_get_busy", 1'b1, 2'd1, 2'd1, '0, W'(8'h77));
        check("pen_busy_status", W'(obs_st), W'(ST_BUSY));
        busy_len += obs_busy ? 1 : 0;
        for (int i = 0; i < 20 && obs_busy; i++) begin
            step("pen_idle", 1'b0, 2'd0, '0, '0, '0);
            busy_len += obs_busy ? 1 : 0;
        end
        check("pen_len", W'(busy_len), W'(PENALTY));
        step("pen_get_after", 1'b1, 2'd1, 2'd1, '0, W'(8'h77));
        check("pen_after_data", obs_out, W'(16'h4242));
`endif

        // Asynchronous reset in the middle of a cycle right after a STORE
        step("ar_store", 1'b1, 2'd0, 2'd2, W'(16'h9999), W'(8'h09));
        #2;
        resetn = 1'b0;
        #1;
        check("ar.valid", W'(rsp_valid), '0);
        check("ar.status", W'(rsp_status), W'(ST_NONE));
        check("ar.out", out, '0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        step("ar_get", 1'b1, 2'd1, 2'd2, '0, W'(8'h09));
        check("ar_get_reject", W'(obs_st), W'(ST_REJECT));

        // Random traffic; small password alphabet so matches are frequent
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), SW'($urandom_range(0, SLOTS - 1)),
                 {$urandom, $urandom, $urandom, $urandom}, W'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lockbox_bank.md
Name: lockbox_bank

Overview:
- Multi-slot successor to the single-slot lockbox. Holds up to SLOTS independent secret/password pairs, each with its own failed-attempt counter and permanent lockout.
- Sits behind the HSM command decoder. One request per cycle; registered response one cycle later.
- A secret leaves the block only on a successful get. Every other path returns zero.

Parameters:
- WIDTH, 128: secret and password width in bits.
- SLOTS, 4: number of slots. Must be at least 2.
- MAX_TRIES, 3: consecutive failed gets that lock a slot. Must be at least 1.
- PENALTY_CYCLES, 8: stall length after a failed get. Used only with LOCKBOX_BANK_PENALTY_EN.

Ports:
- clk, input, 1: clock, rising edge.
- resetn, input, 1: reset, asynchronous, active-low.
- en, input, 1: request valid.
- op, input, 2: request opcode. 0 = STORE, 1 = GET, 2 = WIPE, 3 = reserved.
- slot, input, $clog2(SLOTS): target slot.
- secret, input, WIDTH: secret for STORE.
- password, input, WIDTH: password for STORE or GET.
- out, output, WIDTH: returned secret. Zero unless rsp_status = OK after a GET.
- rsp_valid, output, 1: response present this cycle.
- rsp_status, output, 3: NONE=0, OK=1, MISMATCH=2, LOCKED=3, REJECT=4, BUSY=5.
- busy, output, 1: penalty stall active. Tied to 0 without the macro.

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values:
  - out = 0, rsp_valid = 0, rsp_status = NONE, busy = 0.
  - Every slot goes to EMPTY with secret, password and counter cleared to 0.
  - Reset mid-operation discards any in-flight response.
- Latency:
  - A request sampled with en=1 at edge N produces rsp_valid=1 with status after edge N, for exactly one cycle.
  - en=0 gives rsp_valid=0, out=0 and rsp_status=NONE the next cycle.
- Per-slot states: EMPTY, FULL, LOCKED.
- STORE:
  - EMPTY: latch secret and password, clear counter, go to FULL, status OK, out=0.
  - FULL or LOCKED: no change, status REJECT.
- GET on FULL, password matches:
  - out = stored secret, status OK.
  - Slot goes to EMPTY and secret, password and counter are cleared.
- GET on FULL, password mismatches:
  - counter += 1, out = 0.
  - If the new counter equals MAX_TRIES: zero the secret, go to LOCKED, status LOCKED.
  - Otherwise: status MISMATCH.
- GET on EMPTY: status REJECT, out=0. GET on LOCKED: status LOCKED, out=0, counter unchanged.
- WIDTH-bit compare rule: an all-zero password stored in a FULL slot is legal and compares normally. EMPTY is tracked by state, not by value.
- WIDTH-bit compare rule: counter width is $clog2(MAX_TRIES+1) and saturates at MAX_TRIES. It never wraps.
- WIPE: any state goes to EMPTY with all fields cleared, status OK. This is the only exit from LOCKED.
- op=3: status REJECT, no state change.
- slot >= SLOTS (non-power-of-2 SLOTS): status REJECT, no state change.
- Isolation: a request touches only the addressed slot. Other slots are untouched.
- out carries no data from any slot except on a successful GET.

Optional Feature:
- Macro: LOCKBOX_BANK_PENALTY_EN.
- Defined:
  - Any MISMATCH or LOCKED-causing GET loads a down-counter with PENALTY_CYCLES. busy=1 while it is non-zero.
  - Requests with en=1 while busy=1 are dropped with no state change, rsp_valid=1 and status BUSY.
  - The counter decrements every cycle and is cleared by reset.
  - A failure does not extend a running penalty, because failures cannot occur while busy.
- Undefined: no penalty counter, busy tied 0, status BUSY never produced.

Decomposition:
- Package lockbox_bank_pkg holds:
  - op encodings (STORE, GET, WIPE);
  - rsp_status encodings;
  - the slot-state enum (EMPTY, FULL, LOCKED).
- Sub-module lockbox_bank_slot, one instance per slot via generate.
  - Holds state, secret, password and counter.
  - Takes a decoded per-slot request and returns a status code plus secret-on-success.
- The top level does slot decode, response muxing, the response register and the penalty counter.

Test Plan:
- STORE slot 1 (secret=0xAAAA, pw=0x1234), then GET slot 1 pw=0x1234 -> next cycle out=0xAAAA, status OK. A repeat GET gives REJECT with out=0.
- STORE slot 0 twice -> second gets REJECT, original secret still retrievable.
- MAX_TRIES=3: GET slot 2 with a wrong pw three times -> MISMATCH, MISMATCH, LOCKED. A following correct-pw GET gives LOCKED with out=0. WIPE gives OK, then STORE gives OK.
- Fill slots 0 and 3. Fail GET on slot 0 twice, then correct GET slot 3 -> OK with slot 3's secret, and slot 0's counter is unaffected (a third failure on slot 0 locks it).
- Assert resetn low asynchronously mid-cycle after a STORE -> outputs zero immediately. A GET after release gives REJECT.
- With LOCKBOX_BANK_PENALTY_EN and PENALTY_CYCLES=8:
  - a failed GET -> busy=1 for 8 cycles;
  - a correct GET during the stall -> BUSY and the slot is unchanged;
  - the same GET after busy falls -> OK.
